// File: rtl/divider_restoring_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Companion to the shift-add multiplier; quotient/remainder hold the last result until the next done.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// CALC  | one shift-subtract step per edge, size steps total
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module divider_restoring_seq #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(size + 1);

    state_t          state_q, state_d;
    logic [size-1:0] prem_q, prem_d;
    logic [size-1:0] dvd_q, dvd_d;
    logic [size-1:0] dsr_q, dsr_d;
    logic [size-1:0] quo_q, quo_d;
    logic [size-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dbz_q, dbz_d;

    logic [size:0]   shifted;
    logic [size-1:0] diff;
    logic            qbit;

    // Partial remainder stays below the divisor, so the modular size-bit
    // difference is exact whenever the trial subtraction succeeds.
    assign shifted = {prem_q, dvd_q[size-1]};
    assign qbit    = (shifted >= {1'b0, dsr_q});
    assign diff    = shifted[size-1:0] - dsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    prem_d = '0;
                    dvd_d  = dividend;
                    dsr_d  = divisor;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = qbit ? diff : shifted[size-1:0];
                dvd_d  = {dvd_q[size-2:0], qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(size - 1)) begin
                    state_d = DONE;
                    quo_d   = dvd_d;
                    rem_d   = prem_d;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Self-checking bench for divider_restoring_seq: directed table, multi-cycle corner
// sequences and random operands against a plain-arithmetic reference.
module tb_divider_restoring_seq;

    localparam int SIZE = 8;
    localparam int TMO  = 40;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            busy;
    logic            done;
    logic            div_by_zero;

    int n_vec;
    int n_bad;

    divider_restoring_seq #(.size(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive start for exactly one edge; returns at the first negedge after acceptance.
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = SIZE'(a);
        divisor  = SIZE'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = SIZE'($urandom);
        divisor  = SIZE'($urandom);
    endtask

    // Latency is counted in clock edges after the accepting edge: a nonzero divisor
    // reaches DONE after SIZE steps, a zero divisor goes to DONE on the accepting edge.
    task automatic wait_result(input string tag, input int cyc0, input int exp_cyc,
                               input int exp_busy, input int q, input int r, input int dbz);
        int cyc;
        int nbusy;
        cyc   = cyc0;
        nbusy = 0;
        while (!done && cyc < TMO) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_seen"}, int'(done), 1);
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " busy_cycles"}, nbusy, exp_busy);
        check({tag, " busy_at_done"}, int'(busy), 0);
        check({tag, " quotient"}, int'(quotient), q);
        check({tag, " remainder"}, int'(remainder), r);
        check({tag, " div_by_zero"}, int'(div_by_zero), dbz);
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int q, r, dbz, lat;
        if (b == 0) begin
            q = (1 << SIZE) - 1; r = a; dbz = 1; lat = 0;
        end else begin
            q = a / b; r = a % b; dbz = 0; lat = SIZE;
        end
        @(negedge clk);
        start_op(a, b);
        wait_result(tag, 0, lat, lat, q, r, dbz);
        @(negedge clk);
        check({tag, " done_one_cycle"}, int'(done), 0);
        check({tag, " hold_quotient"}, int'(quotient), q);
    endtask

    vec_t tbl[$];

    initial begin
        int a, b, pulses;
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        tbl.push_back('{200, 7, 28, 4, 0});
        tbl.push_back('{255, 1, 255, 0, 0});
        tbl.push_back('{5, 9, 0, 5, 0});
        tbl.push_back('{255, 255, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 0});
        tbl.push_back('{100, 0, 255, 100, 1});
        tbl.push_back('{9, 3, 3, 0, 0});

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle after reset", int'(busy | done), 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            start_op(tbl[i].a, tbl[i].b);
            wait_result($sformatf("tbl%0d %0d/%0d", i, tbl[i].a, tbl[i].b), 0,
                        (tbl[i].b == 0) ? 0 : SIZE, (tbl[i].b == 0) ? 0 : SIZE,
                        tbl[i].q, tbl[i].r, tbl[i].dbz);
            @(negedge clk);
            check($sformatf("tbl%0d done_pulse", i), int'(done), 0);
        end

        // start while busy must be ignored
        @(negedge clk);
        start_op(200, 7);
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd2;
        @(negedge clk);
        start    = 1'b0;
        wait_result("ignore_start", 3, SIZE, SIZE - 3, 28, 4, 0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_start extra_done", pulses, 0);

        // back-to-back: start held in the DONE cycle
        @(negedge clk);
        start_op(200, 7);
        wait_result("b2b first", 0, SIZE, SIZE, 28, 4, 0);
        start_op(17, 5);
        check("b2b no_idle", int'(busy), 1);
        wait_result("b2b second", 0, SIZE, SIZE, 3, 2, 0);

        // asynchronous reset mid-division
        @(negedge clk);
        start_op(200, 7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async busy", int'(busy), 0);
        check("async done", int'(done), 0);
        check("async quotient", int'(quotient), 0);
        check("async remainder", int'(remainder), 0);
        check("async dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) pulses++;
        end
        check("post_reset idle", pulses, 0);
        run_op("post_reset op", 143, 11);

        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(255, 0);
            b = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(255, 1);
            run_op($sformatf("rnd%0d %0d/%0d", i, a, b), a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
